scan_display: RTL and testbench

SCAN_DISPLAY -- requirements
Module: scan_display

---
 rtl/scan_display_pkg.sv | 25 ++
 rtl/scan_display_seg7_decode.sv | 32 +++
 rtl/scan_display.sv | 131 +++++++++++++
 tb/tb_scan_display.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/scan_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scan_display_pkg : seven-segment glyphs and special BCD codes  (rev 1.0)   |
// +----------------------------------------------------------------------------+
package scan_display_pkg;

  // Glyph bit order is a..g, msb = a
  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_MINUS = 7'b0000001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_MINUS = 4'hB;
  localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage
`default_nettype wire

// File: rtl/scan_display_seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decode : BCD / minus / blank code to a..g glyph, combinational (1.0) |
// +----------------------------------------------------------------------------+
module seg7_decode
  import scan_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (code)
      4'd0:       seg = GLYPH_0;
      4'd1:       seg = GLYPH_1;
      4'd2:       seg = GLYPH_2;
      4'd3:       seg = GLYPH_3;
      4'd4:       seg = GLYPH_4;
      4'd5:       seg = GLYPH_5;
      4'd6:       seg = GLYPH_6;
      4'd7:       seg = GLYPH_7;
      4'd8:       seg = GLYPH_8;
      4'd9:       seg = GLYPH_9;
      CODE_MINUS: seg = GLYPH_MINUS;
      CODE_BLANK: seg = GLYPH_BLANK;
      default:    seg = GLYPH_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scan_display : multiplexed 7-segment scanner, frame-synchronous load (1.0)|
// +----------------------------------------------------------------------------+
module scan_display
  import scan_display_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 10000,
  parameter int COMMON_ANODE = 0,
  parameter int BLANK_LZ     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  enable,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0]        SEG_OFF = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = (COMMON_ANODE != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   frame_start_q, frame_start_d;
  logic [4*DIGITS-1:0]    disp_q, disp_d, pend_q, pend_d;
  logic [DIGITS-1:0]      disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [7:0]             segment_q, segment_d;
  logic [DIGITS-1:0]      digit_sel_q, digit_sel_d;

  logic                   tc, wrap, lead;
  logic [DIGITS-1:0]      blank_mask, sel_raw;
  logic [3:0]             cur_code;
  logic [6:0]             cur_glyph;
  logic [7:0]             seg_raw;

  assign cur_code = disp_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .code (cur_code),
    .seg  (cur_glyph)
  );

  // A digit is blanked while every more-significant code, itself included, is zero
  always_comb begin
    lead       = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead          = lead & (disp_q[4*i +: 4] == 4'h0);
      blank_mask[i] = (BLANK_LZ != 0) && lead && (i != 0);
    end
  end

  always_comb begin
    tc            = (presc_q == PW'(SCAN_DIV - 1));
    wrap          = tc && (idx_q == IW'(DIGITS - 1));
    presc_d       = tc ? '0 : presc_q + 1'b1;
    idx_d         = idx_q;
    if (tc) idx_d = wrap ? '0 : idx_q + 1'b1;
    frame_start_d = wrap;

    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    // A load landing on the wrap edge bypasses the pending buffer
    if (wrap) begin
      if (load) begin
        disp_d    = digits_in;
        disp_dp_d = dp_in;
      end else if (pend_vld_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end

    seg_raw = 8'h00;
    sel_raw = '0;
    if (enable) begin
      seg_raw        = {(blank_mask[idx_q] ? GLYPH_BLANK : cur_glyph), disp_dp_q[idx_q]};
      sel_raw[idx_q] = 1'b1;
    end
    segment_d   = (COMMON_ANODE != 0) ? ~seg_raw : seg_raw;
    digit_sel_d = (COMMON_ANODE != 0) ? ~sel_raw : sel_raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
      disp_q        <= {DIGITS{CODE_BLANK}};
      disp_dp_q     <= '0;
      pend_q        <= {DIGITS{CODE_BLANK}};
      pend_dp_q     <= '0;
      pend_vld_q    <= 1'b0;
      segment_q     <= SEG_OFF;
      digit_sel_q   <= SEL_OFF;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_start_q <= frame_start_d;
      disp_q        <= disp_d;
      disp_dp_q     <= disp_dp_d;
      pend_q        <= pend_d;
      pend_dp_q     <= pend_dp_d;
      pend_vld_q    <= pend_vld_d;
      segment_q     <= segment_d;
      digit_sel_q   <= digit_sel_d;
    end
  end

  assign segment     = segment_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scan_display : three scanner variants against a frame-level model (1.0)|
// +----------------------------------------------------------------------------+
module tb_scan_display;

  localparam int D = 4;
  localparam int S = 4;
  localparam int FRAME = D * S;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits_in = 16'h0000;
  logic [3:0]    dp_in = 4'h0;
  logic          load = 1'b0;
  logic          enable = 1'b1;

  logic [7:0]    seg_a, seg_c, seg_n;
  logic [3:0]    sel_a, sel_c, sel_n;
  logic          fs_a, fs_c, fs_n;

  int n_checks = 0;
  int n_fails  = 0;

  // model: edges since reset release, shown value, pending value
  int          m_n;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv;
  logic [7:0]  glyph_tab [16];

  always #5 clk = ~clk;

  scan_display #(.DIGITS(D), .SCAN_DIV(S), .COMMON_ANODE(0), .BLANK_LZ(1)) u_dut_cc (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .segment(seg_a), .digit_sel(sel_a), .frame_start(fs_a));

  scan_display #(.DIGITS(D), .SCAN_DIV(S), .COMMON_ANODE(1), .BLANK_LZ(1)) u_dut_ca (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .segment(seg_c), .digit_sel(sel_c), .frame_start(fs_c));

  scan_display #(.DIGITS(D), .SCAN_DIV(S), .COMMON_ANODE(0), .BLANK_LZ(0)) u_dut_nlz (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .enable(enable), .segment(seg_n), .digit_sel(sel_n), .frame_start(fs_n));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t, edge %0d)", tag, got, exp, $time, m_n);
    end
  endtask

  // Active-high segment byte a..g,dp for digit idx of the shown value
  function automatic logic [7:0] model_seg(input int idx, input bit lz);
    bit lead = 1'b1;
    bit blank;
    logic [3:0] code;
    logic [7:0] g;
    for (int j = D - 1; j >= idx; j--) lead &= (m_disp[4*j +: 4] == 4'h0);
    blank = lz && (idx != 0) && lead;
    code  = m_disp[4*idx +: 4];
    g     = glyph_tab[code];
    return {(blank ? 7'b0 : g[7:1]), m_dp[idx]};
  endfunction

  task automatic model_reset();
    m_n = 0; m_disp = 16'hFFFF; m_pend = 16'hFFFF; m_dp = 4'h0; m_pdp = 4'h0; m_pv = 1'b0;
  endtask

  task automatic check_inactive(input string tag);
    check({tag, "_seg_cc"}, {24'h0, seg_a}, 32'h00);
    check({tag, "_sel_cc"}, {28'h0, sel_a}, 32'h0);
    check({tag, "_seg_ca"}, {24'h0, seg_c}, 32'hFF);
    check({tag, "_sel_ca"}, {28'h0, sel_c}, 32'hF);
    check({tag, "_fs"},     {29'h0, fs_a, fs_c, fs_n}, 32'h0);
  endtask

  // Called just after a rising edge; returns just after a rising edge
  task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dp, input bit en);
    int idx;
    logic [7:0] e_lz, e_nlz, x_a, x_c, x_n;
    logic [3:0] onehot, s_a, s_c;
    bit e_fs;
    idx    = (m_n / S) % D;
    e_lz   = model_seg(idx, 1'b1);
    e_nlz  = model_seg(idx, 1'b0);
    onehot = 4'(1 << idx);
    x_a = en ? e_lz : 8'h00;
    x_c = en ? ~e_lz : 8'hFF;
    x_n = en ? e_nlz : 8'h00;
    s_a = en ? onehot : 4'h0;
    s_c = ~s_a;
    m_n++;
    e_fs = (m_n % FRAME) == 0;
    if (e_fs) begin
      if (ld) begin m_disp = d; m_dp = dp; end
      else if (m_pv) begin m_disp = m_pend; m_dp = m_pdp; end
      m_pv = 1'b0;
    end else if (ld) begin
      m_pend = d; m_pdp = dp; m_pv = 1'b1;
    end
    load = ld; digits_in = d; dp_in = dp; enable = en;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("seg_cc",  {24'h0, seg_a}, {24'h0, x_a});
    check("sel_cc",  {28'h0, sel_a}, {28'h0, s_a});
    check("fs_cc",   {31'h0, fs_a},  {31'h0, e_fs});
    check("seg_ca",  {24'h0, seg_c}, {24'h0, x_c});
    check("sel_ca",  {28'h0, sel_c}, {28'h0, s_c});
    check("fs_ca",   {31'h0, fs_c},  {31'h0, e_fs});
    check("seg_nlz", {24'h0, seg_n}, {24'h0, x_n});
    check("sel_nlz", {28'h0, sel_n}, {28'h0, s_a});
    check("fs_nlz",  {31'h0, fs_n},  {31'h0, e_fs});
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step(1'b0, 16'h0000, 4'h0, 1'b1);
  endtask

  // Asynchronous reset raised between edges; a load during it must be lost
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_inactive("rst_async");
    load = 1'b1; digits_in = 16'h1234; dp_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check_inactive("rst_hold");
    load = 1'b0;
    rst  = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    for (int k = 0; k < 16; k++) glyph_tab[k] = 8'h00;
    glyph_tab[0] = 8'hFC; glyph_tab[1] = 8'h60; glyph_tab[2] = 8'hDA; glyph_tab[3] = 8'hF2;
    glyph_tab[4] = 8'h66; glyph_tab[5] = 8'hB6; glyph_tab[6] = 8'hBE; glyph_tab[7] = 8'hE0;
    glyph_tab[8] = 8'hFE; glyph_tab[9] = 8'hF6; glyph_tab[11] = 8'h02;
    model_reset();

    load = 1'b1; digits_in = 16'h8888; dp_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_inactive("reset");
    load = 1'b0;
    rst  = 1'b0;

    idle(2 * FRAME + 2);
    step(1'b1, 16'h0042, 4'h0, 1'b1);
    idle(2 * FRAME + 4);
    step(1'b1, 16'hFB07, 4'h0, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h5678, 4'h0, 1'b1);
    idle(FRAME + 5);
    step(1'b1, 16'h1234, 4'h0, 1'b1);
    idle(3);
    step(1'b1, 16'h9999, 4'h0, 1'b1);
    idle(2 * FRAME);
    step(1'b1, 16'h0000, 4'b0010, 1'b1);
    idle(2 * FRAME);
    for (int k = 0; k < 10; k++) step(1'b0, 16'h0000, 4'h0, 1'b0);
    idle(FRAME + 3);

    // Pending load followed by a load exactly on the wrap edge
    step(1'b1, 16'h4444, 4'h1, 1'b1);
    while ((m_n % FRAME) != FRAME - 1) idle(1);
    step(1'b1, 16'h0123, 4'h8, 1'b1);
    idle(FRAME + 2);

    // Reset while digit 2 is being scanned
    while (((m_n / S) % D) != 2) idle(1);
    apply_reset();
    idle(FRAME + 4);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      step(($urandom_range(0, 7) == 0), rand_digits(), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
